// File: rtl/key_link_pkg.sv
// key_link_pkg: types and constants shared by the key link rx and tx.
// No ports; imported by every file of the link.
package key_link_pkg;

  localparam int KEY_BYTES = 32;
  localparam int KEY_W     = KEY_BYTES * 8;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_FRAMING  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    FR_WAIT_SOF,
    FR_PAYLOAD,
    FR_CHECK
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } bit_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 2-flop synchronizer plus 8N1 LSB-first byte receiver.
// Ports: clk_i, rst_ni, rx_serial_i in; byte_o, byte_valid_o, framing_err_o out.
module uart_byte_rx
  import key_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_serial_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       framing_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);

  logic          s1;
  logic          s2;
  bit_state_t    st;
  bit_state_t    st_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          half_hit;
  logic          full_hit;

  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);

  // Idle-high line: sync flops come out of reset at 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx_serial_i;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st <= RX_IDLE;
    else         st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      RX_IDLE:
        if (!s2) st_n = RX_START;
      RX_START:
        if (half_hit) st_n = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (full_hit && bit_cnt == 3'd7) st_n = RX_STOP;
      RX_STOP:
        if (full_hit) st_n = RX_IDLE;
      default:
        st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      unique case (st)
        RX_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
        end
        RX_START:
          cnt <= half_hit ? '0 : cnt + 1'b1;
        RX_DATA:
          if (full_hit) begin
            cnt     <= '0;
            sh      <= {s2, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        RX_STOP:
          cnt <= full_hit ? '0 : cnt + 1'b1;
        default:
          cnt <= '0;
      endcase
    end
  end

  always_comb begin
    byte_valid_o  = 1'b0;
    framing_err_o = 1'b0;
    if (st == RX_STOP && full_hit) begin
      byte_valid_o  = s2;
      framing_err_o = !s2;
    end
  end

  assign byte_o = sh;

endmodule

// File: rtl/key_frame_rx.sv
// key_frame_rx: frames UART bytes as SOF + 32 key bytes + XOR csum.
// Ports: clk_i, rst_ni, rx_serial_i, clear_i in; key_o, key_valid_o, busy_o, err_o, err_code_o out.
module key_frame_rx
  import key_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 20 * 10 * CLKS_PER_BIT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_serial_i,
  input  logic             clear_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CLKS);

  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_ferr;

  frame_state_t     st;
  frame_state_t     st_n;
  logic [4:0]       idx;
  logic [7:0]       csum;
  logic [KEY_W-1:0] shadow;
  logic [TW-1:0]    tcnt;

  logic             open_q;
  logic             to_hit;
  logic             byte_take;
  logic             key_load;
  logic             err_set;
  logic [1:0]       err_code_n;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_serial_i   (rx_serial_i),
    .byte_o        (rx_byte),
    .byte_valid_o  (rx_valid),
    .framing_err_o (rx_ferr)
  );

  assign open_q = (st != FR_WAIT_SOF);
  assign busy_o = open_q;
  // A byte arriving on the timeout cycle wins.
  assign to_hit = open_q && (tcnt == TO_MAX) && !rx_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st <= FR_WAIT_SOF;
    else         st <= st_n;
  end

  always_comb begin
    st_n = st;
    if (clear_i) begin
      st_n = FR_WAIT_SOF;
    end else begin
      unique case (st)
        FR_WAIT_SOF:
          if (rx_valid && rx_byte == SOF_BYTE)
            st_n = FR_PAYLOAD;
        FR_PAYLOAD:
          if (rx_ferr || to_hit)
            st_n = FR_WAIT_SOF;
          else if (rx_valid && idx == 5'd31)
            st_n = FR_CHECK;
        FR_CHECK:
          if (rx_ferr || rx_valid || to_hit)
            st_n = FR_WAIT_SOF;
        default:
          st_n = FR_WAIT_SOF;
      endcase
    end
  end

  always_comb begin
    byte_take  = 1'b0;
    key_load   = 1'b0;
    err_set    = 1'b0;
    err_code_n = ERR_NONE;
    if (!clear_i && open_q) begin
      byte_take = rx_valid && (st == FR_PAYLOAD);
      if (rx_ferr) begin
        err_set    = 1'b1;
        err_code_n = ERR_FRAMING;
      end else if (to_hit) begin
        err_set    = 1'b1;
        err_code_n = ERR_TIMEOUT;
      end else if (rx_valid && st == FR_CHECK) begin
        if (rx_byte == csum) begin
          key_load = 1'b1;
        end else begin
          err_set    = 1'b1;
          err_code_n = ERR_CHECKSUM;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_o       <= '0;
      key_valid_o <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      shadow      <= '0;
      idx         <= '0;
      csum        <= '0;
      tcnt        <= '0;
    end else begin
      key_valid_o <= key_load;
      err_o       <= err_set;
      if (err_set) err_code_o <= err_code_n;

      if (clear_i)       key_o <= '0;
      else if (key_load) key_o <= shadow;

      // Partial key material never outlives its frame.
      if (clear_i || (open_q && st_n == FR_WAIT_SOF))
        shadow <= '0;
      else if (byte_take)
        shadow[{idx, 3'b000} +: 8] <= rx_byte;

      if (st == FR_WAIT_SOF) begin
        idx  <= '0;
        csum <= '0;
      end else if (byte_take) begin
        if (idx != 5'd31) idx <= idx + 5'd1;
        csum <= csum ^ rx_byte;
      end

      if (!open_q || rx_valid)
        tcnt <= '0;
      else if (tcnt != TO_MAX)
        tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_key_frame_rx.sv
// tb_key_frame_rx: directed vectors and corner sequences for key_frame_rx.
// Drives the serial line at CPB clocks/bit and counts output pulses.
module tb_key_frame_rx;
  import key_link_pkg::*;

  localparam int CPB     = 8;
  localparam int TO_CLKS = 20 * 10 * CPB;

  logic         clk    = 1'b0;
  logic         rst_ni = 1'b0;
  logic         rx     = 1'b1;
  logic         clear  = 1'b0;
  logic [255:0] key;
  logic         kv;
  logic         busy;
  logic         err;
  logic [1:0]   code;

  key_frame_rx #(
    .CLKS_PER_BIT (CPB),
    .SOF_BYTE     (8'hA5),
    .TIMEOUT_CLKS (TO_CLKS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_serial_i (rx),
    .clear_i     (clear),
    .key_o       (key),
    .key_valid_o (kv),
    .busy_o      (busy),
    .err_o       (err),
    .err_code_o  (code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kv_seen = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (kv)  kv_seen  <= kv_seen + 1;
    if (err) err_seen <= err_seen + 1;
  end

  typedef struct {
    logic [7:0] first;
    logic [7:0] step;
    logic       bad;
    int         exp_kv;
    int         exp_err;
    logic [1:0] exp_code;
  } vec_t;

  vec_t         tbl[5];
  logic [255:0] exp_key;
  logic [255:0] built;
  int           kv0;
  int           e0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] first,
                            input logic [7:0] step,
                            input logic bad,
                            input logic clr,
                            output logic [255:0] k);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    k  = '0;
    send_byte(8'hA5, 1'b1);
    check("busy_after_sof", busy, 1);
    for (int i = 0; i < 32; i++) begin
      b = first + 8'(i) * step;
      k[i*8 +: 8] = b;
      cs = cs ^ b;
      send_byte(b, 1'b1);
    end
    cs = cs ^ {7'b0, bad};
    if (!clr) begin
      send_byte(cs, 1'b1);
    end else begin
      fork
        send_byte(cs, 1'b1);
        begin
          logic hit;
          hit = 1'b0;
          for (int n = 0; n < 12 * CPB && !hit; n++) begin
            @(negedge clk);
            if (dut.rx_valid) begin
              hit   = 1'b1;
              clear = 1'b1;
              @(negedge clk);
              clear = 1'b0;
            end
          end
          check("clear_window_found", hit, 1);
        end
      join
    end
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h01, 1'b0, 1, 0, 2'b00};
    tbl[1] = '{8'h00, 8'h01, 1'b1, 0, 1, 2'b01};
    tbl[2] = '{8'h10, 8'h03, 1'b0, 1, 0, 2'b00};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 1, 0, 2'b00};
    tbl[4] = '{8'hA5, 8'h00, 1'b0, 1, 0, 2'b00};
    exp_key = '0;

    #1;
    check("rst_key", key, 0);
    check("rst_kv", kv, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_code", code, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    idle(4);
    check("post_rst_key", key, 0);

    for (int v = 0; v < 5; v++) begin
      kv0 = kv_seen;
      e0  = err_seen;
      send_frame(tbl[v].first, tbl[v].step,
                 tbl[v].bad, 1'b0, built);
      idle(4);
      if (!tbl[v].bad) exp_key = built;
      check($sformatf("v%0d_kv", v), kv_seen - kv0, tbl[v].exp_kv);
      check($sformatf("v%0d_err", v), err_seen - e0, tbl[v].exp_err);
      check($sformatf("v%0d_key", v), key, exp_key);
      check($sformatf("v%0d_busy", v), busy, 0);
      if (tbl[v].exp_err > 0)
        check($sformatf("v%0d_code", v), code, tbl[v].exp_code);
      if (v == 0) begin
        check("v0_key_lo", key[7:0], 8'h00);
        check("v0_key_hi", key[255:248], 8'h1F);
      end
    end

    // Framing error on payload byte 10.
    kv0 = kv_seen;
    e0  = err_seen;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1);
    send_byte(8'd10, 1'b0);
    idle(3 * CPB);
    check("fe_err", err_seen - e0, 1);
    check("fe_code", code, ERR_FRAMING);
    check("fe_busy", busy, 0);
    check("fe_kv", kv_seen - kv0, 0);
    check("fe_key", key, exp_key);
    kv0 = kv_seen;
    send_frame(8'h20, 8'h07, 1'b0, 1'b0, built);
    idle(4);
    exp_key = built;
    check("fe_next_kv", kv_seen - kv0, 1);
    check("fe_next_key", key, exp_key);

    // Timeout after SOF + 5 bytes.
    kv0 = kv_seen;
    e0  = err_seen;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 1'b1);
    check("to_busy_open", busy, 1);
    idle(TO_CLKS + 10);
    check("to_err", err_seen - e0, 1);
    check("to_code", code, ERR_TIMEOUT);
    check("to_busy", busy, 0);
    check("to_key", key, exp_key);
    send_frame(8'h03, 8'h05, 1'b0, 1'b0, built);
    idle(4);
    exp_key = built;
    check("to_next_kv", kv_seen - kv0, 1);
    check("to_next_key", key, exp_key);

    // Junk bytes and a short glitch before SOF.
    kv0 = kv_seen;
    e0  = err_seen;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle(3 * CPB);
    check("noise_busy", busy, 0);
    send_frame(8'h81, 8'h0B, 1'b0, 1'b0, built);
    idle(4);
    exp_key = built;
    check("noise_err", err_seen - e0, 0);
    check("noise_kv", kv_seen - kv0, 1);
    check("noise_key", key, exp_key);

    // Clear coinciding with a good checksum byte.
    kv0 = kv_seen;
    e0  = err_seen;
    send_frame(8'h33, 8'h01, 1'b0, 1'b1, built);
    idle(4);
    exp_key = '0;
    check("clr_key", key, exp_key);
    check("clr_kv", kv_seen - kv0, 0);
    check("clr_err", err_seen - e0, 0);
    check("clr_busy", busy, 0);

    // Reset in the middle of a payload.
    send_frame(8'h77, 8'h02, 1'b0, 1'b0, built);
    idle(4);
    exp_key = built;
    check("pre_rst_key", key, exp_key);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h11, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    exp_key = '0;
    check("mid_rst_key", key, exp_key);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_kv", kv, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_code", code, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(2 * CPB);
    kv0 = kv_seen;
    send_frame(8'h5C, 8'h0D, 1'b0, 1'b0, built);
    idle(4);
    exp_key = built;
    check("rst_next_kv", kv_seen - kv0, 1);
    check("rst_next_key", key, exp_key);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
